// File: rtl/jtframe_rom_nslots.sv
// Multi-slot ROM read arbiter: each slot keeps a one-word cache and misses are fetched from SDRAM.
// Define JTFRAME_ROM_RR_EN for round-robin arbitration; the default is fixed priority with the lowest slot winning.
module jtframe_rom_nslots #(
  parameter int SDRAMW = 22,
  parameter int SLOTS  = 4,
  parameter int AW     = 20,
  parameter int DW     = 16,
  parameter logic [SLOTS*SDRAMW-1:0] OFFSETS = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SLOTS*AW-1:0]     slot_addr,
  input  logic [SLOTS-1:0]        slot_cs,
  output logic [SLOTS*DW-1:0]     slot_dout,
  output logic [SLOTS-1:0]        slot_ok,
  output logic                    sdram_req,
  input  logic                    sdram_ack,
  output logic [SDRAMW-1:0]       sdram_addr,
  input  logic                    data_dst,
  input  logic                    data_rdy,
  input  logic [15:0]             data_read
);
  localparam int TW = (DW == 8) ? AW-1 : AW;
  localparam int IW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  state_t state, state_nxt;

  logic [SLOTS-1:0][TW-1:0]     waddr, tags;
  logic [SLOTS-1:0][15:0]       cache;
  logic [SLOTS-1:0][SDRAMW-1:0] offs;
  logic [SLOTS-1:0]             valid, pending;
  logic [IW-1:0]                winner, pick, pick_lo;
  logic [TW-1:0]                cap_tag;
  logic                         found;
`ifdef JTFRAME_ROM_RR_EN
  logic [IW-1:0]                last, pick_hi;
  logic                         found_hi;
`endif

  logic unused_dst;
  assign unused_dst = data_dst;

  generate
    for (genvar n = 0; n < SLOTS; n++) begin : g_slot
      logic [AW-1:0] a;
      assign a       = slot_addr[n*AW +: AW];
      assign offs[n] = OFFSETS[n*SDRAMW +: SDRAMW];
      if (DW == 8) begin : g_byte
        assign waddr[n]             = a[AW-1:1];
        assign slot_dout[n*DW +: DW] = a[0] ? cache[n][15:8] : cache[n][7:0];
      end else begin : g_word
        assign waddr[n]             = a;
        assign slot_dout[n*DW +: DW] = cache[n][DW-1:0];
      end
      assign slot_ok[n] = slot_cs[n] & valid[n] & (tags[n] == waddr[n]);
      assign pending[n] = slot_cs[n] & ~slot_ok[n];
    end
  endgenerate

  // Downward scan: the last assignment is the lowest pending index (above
  // the previous winner, for the round-robin candidate).
  always_comb begin
    found   = 1'b0;
    pick_lo = '0;
`ifdef JTFRAME_ROM_RR_EN
    found_hi = 1'b0;
    pick_hi  = '0;
`endif
    for (int i = SLOTS-1; i >= 0; i--) begin
      if (pending[i]) begin
        found   = 1'b1;
        pick_lo = IW'(i);
      end
`ifdef JTFRAME_ROM_RR_EN
      if (pending[i] && (IW'(i) > last)) begin
        found_hi = 1'b1;
        pick_hi  = IW'(i);
      end
`endif
    end
`ifdef JTFRAME_ROM_RR_EN
    pick = found_hi ? pick_hi : pick_lo;
`else
    pick = pick_lo;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (found)     state_nxt = WAIT_ACK;
      WAIT_ACK:  if (sdram_ack) state_nxt = WAIT_DATA;
      WAIT_DATA: if (data_rdy)  state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  // The tag is captured at request time so a mid-access address change
  // leaves the slot missing and it simply refetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      valid      <= '0;
      tags       <= '0;
      cache      <= '0;
      winner     <= '0;
      cap_tag    <= '0;
`ifdef JTFRAME_ROM_RR_EN
      last       <= IW'(SLOTS-1);
`endif
    end else begin
      case (state)
        IDLE: if (found) begin
          winner     <= pick;
          cap_tag    <= waddr[pick];
          sdram_addr <= SDRAMW'(waddr[pick]) + offs[pick];
          sdram_req  <= 1'b1;
`ifdef JTFRAME_ROM_RR_EN
          last       <= pick;
`endif
        end
        WAIT_ACK: if (sdram_ack) sdram_req <= 1'b0;
        WAIT_DATA: if (data_rdy) begin
          valid[winner] <= 1'b1;
          tags[winner]  <= cap_tag;
          cache[winner] <= data_read;
        end
        default: sdram_req <= 1'b0;
      endcase
    end
  end
endmodule

// File: tb/tb_jtframe_rom_nslots.sv
// Randomized bench for jtframe_rom_nslots (4 byte-wide slots, slot 2 offset) against a transaction-level cache model.
module tb_jtframe_rom_nslots;
  localparam int SLOTS = 4, AW = 20, DW = 8, SDRAMW = 22;
  localparam logic [SLOTS*SDRAMW-1:0] OFFS = {22'h0, 22'h100000, 22'h0, 22'h0};

  logic                  clk = 1'b0, rst = 1'b1;
  logic [SLOTS*AW-1:0]   slot_addr = '0;
  logic [SLOTS-1:0]      slot_cs = '0;
  logic [SLOTS*DW-1:0]   slot_dout;
  logic [SLOTS-1:0]      slot_ok;
  logic                  sdram_req, sdram_ack = 1'b0;
  logic [SDRAMW-1:0]     sdram_addr;
  logic                  data_dst = 1'b0, data_rdy = 1'b0;
  logic [15:0]           data_read = '0;

  always #5 clk = ~clk;

  jtframe_rom_nslots #(.SDRAMW(SDRAMW), .SLOTS(SLOTS), .AW(AW), .DW(DW), .OFFSETS(OFFS)) dut (
    .clk(clk), .rst(rst), .slot_addr(slot_addr), .slot_cs(slot_cs), .slot_dout(slot_dout),
    .slot_ok(slot_ok), .sdram_req(sdram_req), .sdram_ack(sdram_ack), .sdram_addr(sdram_addr),
    .data_dst(data_dst), .data_rdy(data_rdy), .data_read(data_read)
  );

  int vecs = 0, errs = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // reference model: phase 0 idle, 1 request outstanding, 2 awaiting data
  int          m_phase = 0, m_win = 0, m_last = SLOTS-1, m_cap = 0;
  bit          m_valid[SLOTS];
  int          m_tag[SLOTS];
  logic [15:0] m_data[SLOTS];
  logic [SDRAMW-1:0] m_addr = '0;

  logic [SLOTS-1:0] cs_v = '0;
  int  a_v[SLOTS];
  bit  rst_v = 1'b1, force_rdy = 1'b0, started = 1'b0, prev_req = 1'b0, rose = 1'b0;
  int  rises = 0;
  int  grants[$];

  function automatic logic [15:0] mem(input logic [SDRAMW-1:0] a);
    logic [31:0] h;
    if (a == 22'h10) return 16'h1234;
    h = {10'd0, a} * 32'h9E3779B1;
    return h[31:16];
  endfunction

  function automatic bit hit(input int s);
    return m_valid[s] && (m_tag[s] == (a_v[s] >> 1));
  endfunction

  task automatic cycle();
    logic [SLOTS-1:0] eok;
    int win, w;
    @(negedge clk);
    rst     = rst_v;
    slot_cs = cs_v;
    for (int s = 0; s < SLOTS; s++) slot_addr[s*AW +: AW] = AW'(a_v[s]);
    sdram_ack = (m_phase == 1) ? ($urandom_range(1, 0) == 0) : ($urandom_range(7, 0) == 0);
    data_rdy  = force_rdy || ((m_phase == 2) ? ($urandom_range(1, 0) == 0) : ($urandom_range(7, 0) == 0));
    data_read = (m_phase == 2) ? mem(m_addr) : 16'($urandom);
    #1;
    for (int s = 0; s < SLOTS; s++) eok[s] = cs_v[s] && hit(s);
    rose = sdram_req && !prev_req;
    prev_req = sdram_req;
    if (started) begin
      if (rose) rises++;
      chk("req", sdram_req, m_phase == 1);
      chk("sdram_addr", sdram_addr, m_addr);
      chk("ok", slot_ok, eok);
      for (int s = 0; s < SLOTS; s++)
        if (eok[s]) chk("dout", slot_dout[s*DW +: DW], (a_v[s] & 1) ? m_data[s][15:8] : m_data[s][7:0]);
    end
    // advance the model to the state after the coming clock edge
    if (rst_v) begin
      m_phase = 0; m_addr = '0; m_last = SLOTS-1; started = 1'b1;
      for (int s = 0; s < SLOTS; s++) begin m_valid[s] = 0; m_data[s] = '0; end
    end else if (m_phase == 0) begin
      win = -1;
`ifdef JTFRAME_ROM_RR_EN
      for (int i = 1; i <= SLOTS; i++) begin
        w = (m_last + i) % SLOTS;
        if (cs_v[w] && !hit(w)) begin win = w; break; end
      end
`else
      for (int i = 0; i < SLOTS; i++)
        if (cs_v[i] && !hit(i)) begin win = i; break; end
`endif
      if (win >= 0) begin
        m_win = win; m_last = win; m_cap = a_v[win] >> 1; m_phase = 1;
        m_addr = SDRAMW'((m_cap + int'(OFFS[win*SDRAMW +: SDRAMW])) % (1 << SDRAMW));
      end
    end else if (m_phase == 1) begin
      if (sdram_ack) m_phase = 2;
    end else if (data_rdy) begin
      m_valid[m_win] = 1; m_tag[m_win] = m_cap; m_data[m_win] = data_read; m_phase = 0;
    end
  endtask

  initial begin
    for (int s = 0; s < SLOTS; s++) begin a_v[s] = 0; m_valid[s] = 0; m_tag[s] = 0; m_data[s] = '0; end
    repeat (2) cycle();
    cs_v = '1;
    cycle();
    chk("rst_ok", slot_ok, 0);
    chk("rst_dout", slot_dout, 0);
    chk("rst_req", sdram_req, 0);
    chk("rst_addr", sdram_addr, 0);
    rst_v = 0; cs_v = '0;

    // byte lanes of one fetched word
    cs_v = 4'b0010; a_v[1] = 'h21; rises = 0;
    for (int n = 0; n < 60; n++) begin cycle(); if (slot_ok[1]) break; end
    chk("byte_ok_hi", slot_ok[1], 1);
    chk("byte_hi", slot_dout[15:8], 8'h12);
    a_v[1] = 'h20;
    cycle();
    chk("byte_ok_lo", slot_ok[1], 1);
    chk("byte_lo", slot_dout[15:8], 8'h34);
    repeat (3) cycle();
    chk("byte_reqs", rises, 1);

    // slot offset
    cs_v = 4'b0100; a_v[2] = 'h8;
    for (int n = 0; n < 60; n++) begin cycle(); if (sdram_req) break; end
    chk("off_addr", sdram_addr, 22'h100004);
    for (int n = 0; n < 60; n++) begin cycle(); if (slot_ok[2]) break; end
    chk("off_ok", slot_ok[2], 1);

    // slots 0 and 3 always missing
    cs_v = 4'b1001;
    for (int c = 0; c < 120; c++) begin
      a_v[0] = 'h200 + 2*c; a_v[3] = 'h800 + 2*c;
      cycle();
      if (rose) grants.push_back(sdram_addr >= 'h400 ? 3 : 0);
    end
    chk("arb_count", grants.size() >= 4, 1);
    for (int k = 0; k < grants.size() && k < 6; k++) begin
`ifdef JTFRAME_ROM_RR_EN
      if (k > 0) chk("arb_rr", grants[k], (grants[k-1] == 0) ? 3 : 0);
`else
      chk("arb_fixed", grants[k], 0);
`endif
    end

    // address change while waiting for data
    cs_v = 4'b0001; a_v[0] = 'h3000;
    for (int n = 0; n < 60; n++) begin cycle(); if (m_phase == 2) break; end
    a_v[0] = 'h3100;
    for (int n = 0; n < 60; n++) begin cycle(); if (rose) break; end
    chk("chg_addr", sdram_addr, 22'h1880);
    chk("chg_ok", slot_ok[0], 0);
    for (int n = 0; n < 60; n++) begin cycle(); if (slot_ok[0]) break; end
    chk("chg_refetch_ok", slot_ok[0], 1);

    // reset in the middle of an access, then a stray data_rdy
    cs_v = 4'b0010; a_v[1] = 'h5000;
    for (int n = 0; n < 60; n++) begin cycle(); if (m_phase == 1) break; end
    rst_v = 1; cycle();
    rst_v = 0; cs_v = '0; force_rdy = 1; cycle();
    chk("midrst_req", sdram_req, 0);
    force_rdy = 0; cs_v = 4'b1111; cycle();
    chk("midrst_ok", slot_ok, 0);
    chk("midrst_req2", sdram_req, 0);

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(3, 0) == 0) cs_v = 4'($urandom);
      for (int s = 0; s < SLOTS; s++)
        if ($urandom_range(5, 0) == 0) a_v[s] = ($urandom_range(9, 0) == 0) ? int'($urandom_range(20'hFFFFF, 0)) : int'($urandom_range(31, 0));
      rst_v = ($urandom_range(299, 0) == 0);
      cycle();
    end
    rst_v = 0;

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/jtframe_rom_nslots.md
JTFRAME_ROM_NSLOTS -- requirements
Module: jtframe_rom_nslots

Interface
REQ-001 SHALL have parameter SDRAMW, default 22: SDRAM word-address width.
REQ-002 SHALL have parameter SLOTS, default 4: channel count, legal range 1..8.
REQ-003 SHALL have parameter AW, default 20: per-slot byte address width.
REQ-004 SHALL have parameter DW, default 16: per-slot data width, 8 or 16 only.
REQ-005 SHALL have parameter OFFSETS, default 0: packed SLOTS*SDRAMW bits, where slot n's word offset is field n.
REQ-006 SHALL have ports clk (in, 1, clock) and rst (in, 1, synchronous active-high reset): one clock; reset is synchronous and active-high.
REQ-007 SHALL have port slot_addr (in, SLOTS*AW): packed byte addresses, with slot n in bits n*AW+:AW.
REQ-008 SHALL have port slot_cs (in, SLOTS): per-slot request.
REQ-009 SHALL have port slot_dout (out, SLOTS*DW): packed read data.
REQ-010 SHALL have port slot_ok (out, SLOTS): data valid for the current address.
REQ-011 SHALL have port sdram_req (out, 1): read request.
REQ-012 SHALL have port sdram_ack (in, 1): request accepted.
REQ-013 SHALL have port sdram_addr (out, SDRAMW): word address.
REQ-014 SHALL have ports data_dst (in, 1; accepted, unused), data_rdy (in, 1; read data valid) and data_read (in, 16; SDRAM word).

Function
REQ-015 Each slot SHALL hold a one-word cache: valid bit, word-address tag (AW-1 bits for DW=8, AW bits for DW=16) and 16-bit data.
REQ-016 slot_ok[n] SHALL be combinational: cs[n] and valid[n] and tag[n] equal to the current word address; a tag mismatch SHALL deassert it in the same cycle.
REQ-017 The slot_dout byte SHALL be selected by addr[0] (0 = low byte) for DW=8; the full word SHALL be output for DW=16.
REQ-018 A slot SHALL be pending when cs is high and it has a cache miss.
REQ-019 The FSM SHALL use the states IDLE, WAIT_ACK and WAIT_DATA.
REQ-020 IDLE: when any slot is pending, the FSM SHALL latch the winner index, set sdram_addr to the winner's word address plus OFFSETS[winner] (modulo 2^SDRAMW), assert sdram_req on the next clock, and go to WAIT_ACK.
REQ-021 WAIT_ACK: sdram_req SHALL stay high and sdram_addr SHALL stay stable until sdram_ack; on ack, req SHALL drop on the next clock and the FSM SHALL go to WAIT_DATA.
REQ-022 WAIT_DATA: on data_rdy, the FSM SHALL write data_read into the winner cache, set valid, write the tag captured at the request, and return to IDLE.
REQ-023 If the winner's address changed during the access, the captured tag SHALL still be written; slot_ok SHALL then stay low, which causes a refetch.
REQ-024 Minimum latency from a cs miss to slot_ok SHALL be 2 cycles plus SDRAM latency: IDLE→req is 1 cycle; data_rdy→ok is 1 cycle.
REQ-025 Simultaneous data_rdy and a new pending slot: the FSM SHALL spend one cycle in IDLE before the next req.
REQ-026 data_rdy outside WAIT_DATA SHALL be ignored.
REQ-027 sdram_ack outside WAIT_ACK SHALL be ignored.
REQ-028 Changing cs during WAIT_ACK or WAIT_DATA SHALL NOT abort the access.

Reset
REQ-029 On rst, the FSM SHALL go to IDLE and sdram_req SHALL be 0.
REQ-030 On rst, sdram_addr SHALL be 0, all valid bits SHALL be 0, slot_ok SHALL be 0 and slot_dout SHALL be 0.
REQ-031 Reset mid-access SHALL drop req the next cycle, and a subsequent data_rdy SHALL be ignored.

Configuration
REQ-032 Macro JTFRAME_ROM_RR_EN defined: arbitration SHALL be round-robin, searching upward from the slot after the last winner and wrapping at SLOTS-1→0; the last-winner pointer SHALL reset to SLOTS-1.
REQ-033 Macro JTFRAME_ROM_RR_EN undefined: arbitration SHALL be fixed priority, with the lowest index winning.

Verification
REQ-034 Single slot, SLOTS=1, DW=16, addr 0x10, ack after 3 cycles, data_rdy with 0xBEEF: sdram_addr=0x10 and slot_ok rises the cycle after data_rdy with dout=0xBEEF; re-read of 0x10 gives ok with no new req.
REQ-035 DW=8, addr 0x21 then 0x20, word 0x1234: dout=0x12 then 0x34, with only one SDRAM req.
REQ-036 OFFSETS slot2=0x100000, slot2 addr 0x4: sdram_addr=0x100004.
REQ-037 Slots 0 and 3 pending every cycle, RR_EN defined: grants alternate 0,3,0,3; RR_EN undefined: all grants to 0 while 0 misses.
REQ-038 Address changed in WAIT_DATA: ok stays low after data_rdy and a second req is issued for the new address.
REQ-039 rst asserted in WAIT_ACK, then data_rdy: req=0, all ok=0 and no cache written.
